// File: rtl/config_pkg.sv
// Core configuration record and the ALU operation encoding shared by the pipeline.
package config_pkg;

   typedef struct packed {
      int unsigned XLEN;
   } config_t;

   localparam config_t DEFAULT_CONF = '{XLEN: 32};

   typedef enum logic [3:0] {
      ALU_OP_ADD  = 4'd0,
      ALU_OP_SUB  = 4'd1,
      ALU_OP_AND  = 4'd2,
      ALU_OP_OR   = 4'd3,
      ALU_OP_XOR  = 4'd4,
      ALU_OP_SLL  = 4'd5,
      ALU_OP_SRL  = 4'd6,
      ALU_OP_SRA  = 4'd7,
      ALU_OP_SLT  = 4'd8,
      ALU_OP_SLTU = 4'd9
   } alu_op_t;

endpackage

// File: rtl/core_id_ex_stage.sv
// Decode-to-execute register with MEM/WB operand forwarding and ALU operand selection.
// One cycle accept-to-valid; id_ready = !ex_valid || ex_ready, so a stalled entry blocks decode.
module core_id_ex_stage #(
   parameter config_pkg::config_t CONF = config_pkg::DEFAULT_CONF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      id_valid,
   output logic                      id_ready,
   input  logic [CONF.XLEN-1:0]      id_pc,
   input  logic [4:0]                id_rs1_addr,
   input  logic [4:0]                id_rs2_addr,
   input  logic [CONF.XLEN-1:0]      id_rs1_data,
   input  logic [CONF.XLEN-1:0]      id_rs2_data,
   input  logic [CONF.XLEN-1:0]      id_imm,
   input  logic                      id_src_a_pc,
   input  logic                      id_src_b_imm,
   input  config_pkg::alu_op_t       id_alu_op,
   input  logic [4:0]                id_rd_addr,
   input  logic                      id_rd_we,
   input  logic                      mem_rd_we,
   input  logic [4:0]                mem_rd_addr,
   input  logic [CONF.XLEN-1:0]      mem_result,
   input  logic                      wb_rd_we,
   input  logic [4:0]                wb_rd_addr,
   input  logic [CONF.XLEN-1:0]      wb_result,
   output logic                      ex_valid,
   input  logic                      ex_ready,
   output logic [CONF.XLEN-1:0]      src_a,
   output logic [CONF.XLEN-1:0]      src_b,
   output config_pkg::alu_op_t       alu_op,
   output logic [CONF.XLEN-1:0]      ex_rs2_data,
   output logic [CONF.XLEN-1:0]      ex_pc,
   output logic [4:0]                ex_rd_addr,
   output logic                      ex_rd_we
);

   localparam int XLEN = CONF.XLEN;

   logic                valid_q, valid_d;
   logic [XLEN-1:0]     pc_q, pc_d;
   logic [XLEN-1:0]     imm_q, imm_d;
   logic [XLEN-1:0]     a_q, a_d;
   logic [XLEN-1:0]     b_q, b_d;
   logic [4:0]          rs1_addr_q, rs1_addr_d;
   logic [4:0]          rs2_addr_q, rs2_addr_d;
   logic                src_a_pc_q, src_a_pc_d;
   logic                src_b_imm_q, src_b_imm_d;
   config_pkg::alu_op_t alu_op_q, alu_op_d;
   logic [4:0]          rd_addr_q, rd_addr_d;
   logic                rd_we_q, rd_we_d;

   logic                load;
   logic                hold;
   logic [XLEN-1:0]     rs1_f;
   logic [XLEN-1:0]     rs2_f;

   // MEM is younger than WB, so it wins; x0 is hardwired and never forwarded.
   function automatic logic [XLEN-1:0] fwd(input logic [XLEN-1:0] value, input logic [4:0] addr);
      if (addr != 5'd0 && mem_rd_we && mem_rd_addr == addr)
         return mem_result;
      else if (addr != 5'd0 && wb_rd_we && wb_rd_addr == addr)
         return wb_result;
      else
         return value;
   endfunction

   assign id_ready = !valid_q || ex_ready;
   assign load     = id_valid && id_ready && !flush;
   assign hold     = valid_q && !ex_ready && !flush;

   assign rs1_f = fwd(a_q, rs1_addr_q);
   assign rs2_f = fwd(b_q, rs2_addr_q);

   always_comb begin
      valid_d     = valid_q;
      pc_d        = pc_q;
      imm_d       = imm_q;
      a_d         = a_q;
      b_d         = b_q;
      rs1_addr_d  = rs1_addr_q;
      rs2_addr_d  = rs2_addr_q;
      src_a_pc_d  = src_a_pc_q;
      src_b_imm_d = src_b_imm_q;
      alu_op_d    = alu_op_q;
      rd_addr_d   = rd_addr_q;
      rd_we_d     = rd_we_q;

      if (flush)
         valid_d = 1'b0;
      else if (id_ready)
         valid_d = id_valid;

      if (load) begin
         pc_d        = id_pc;
         imm_d       = id_imm;
         a_d         = fwd(id_rs1_data, id_rs1_addr);
         b_d         = fwd(id_rs2_data, id_rs2_addr);
         rs1_addr_d  = id_rs1_addr;
         rs2_addr_d  = id_rs2_addr;
         src_a_pc_d  = id_src_a_pc;
         src_b_imm_d = id_src_b_imm;
         alu_op_d    = id_alu_op;
         rd_addr_d   = id_rd_addr;
         rd_we_d     = id_rd_we;
      end else if (hold) begin
         // Absorb producers that retire while stalled so their results are not lost.
         a_d = rs1_f;
         b_d = rs2_f;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         imm_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rs1_addr_q  <= '0;
         rs2_addr_q  <= '0;
         src_a_pc_q  <= 1'b0;
         src_b_imm_q <= 1'b0;
         alu_op_q    <= config_pkg::ALU_OP_ADD;
         rd_addr_q   <= '0;
         rd_we_q     <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         pc_q        <= pc_d;
         imm_q       <= imm_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rs1_addr_q  <= rs1_addr_d;
         rs2_addr_q  <= rs2_addr_d;
         src_a_pc_q  <= src_a_pc_d;
         src_b_imm_q <= src_b_imm_d;
         alu_op_q    <= alu_op_d;
         rd_addr_q   <= rd_addr_d;
         rd_we_q     <= rd_we_d;
      end
   end

   assign ex_valid    = valid_q;
   assign src_a       = src_a_pc_q ? pc_q : rs1_f;
   assign src_b       = src_b_imm_q ? imm_q : rs2_f;
   assign alu_op      = alu_op_q;
   assign ex_rs2_data = rs2_f;
   assign ex_pc       = pc_q;
   assign ex_rd_addr  = rd_addr_q;
   assign ex_rd_we    = rd_we_q && valid_q;

endmodule
